// File: rtl/frontend_command_definition_pkg.sv
// Shared types for the frontend command issuer and its backend command bus.
// Holds widths, backend command format, queued request format and FSM states.
package frontend_command_definition_pkg;

  localparam int DATA_W     = 128;
  localparam int ROW_W      = 14;
  localparam int COL_W      = 4;
  localparam int TAG_W      = 4;
  localparam int CMDQ_DEPTH = 4;
  localparam int RD_MAX     = 4;
  localparam int OUT_W      = $clog2(RD_MAX + 1);

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_type_e;

  typedef struct packed {
    op_type_e           op_type;
    logic [ROW_W-1:0]   row_addr;
    logic [COL_W-1:0]   col_addr;
  } backend_command_t;

  typedef struct packed {
    logic               write;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  wdata;
  } issuer_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_STALL = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/frontend_cmd_issuer_sync_fifo.sv
// Small synchronous FIFO with a combinational head view.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Frontend command issuer: queues host requests, issues backend commands,
// returns read data in order. ISSUER_PERF_CNT_EN adds perf counter ports.
module frontend_cmd_issuer
  import frontend_command_definition_pkg::*;
(
  input  logic                  clk,
  input  logic                  power_on_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ROW_W-1:0]      i_req_row,
  input  logic [COL_W-1:0]      i_req_col,
  input  logic [TAG_W-1:0]      i_req_tag,
  input  logic [DATA_W-1:0]     i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic [TAG_W-1:0]      o_rsp_tag,
  output logic                  o_frontend_command_valid,
  input  logic                  i_backend_controller_ready,
  output backend_command_t      o_frontend_command,
  output logic [DATA_W-1:0]     o_frontend_write_data,
  input  logic                  i_backend_read_data_valid,
  input  logic [DATA_W-1:0]     i_backend_read_data,
  output logic                  o_backend_controller_ren,
  output logic [OUT_W-1:0]      o_rd_outstanding,
  output logic                  o_err
`ifdef ISSUER_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_rd_cnt,
  output logic [31:0]           o_perf_wr_cnt,
  output logic [31:0]           o_perf_stall_cnt
`endif
);

  issuer_state_e     state;
  issuer_state_e     nxt;
  issuer_req_t       req_in;
  issuer_req_t       cmdq_head;
  logic              cmdq_full;
  logic              cmdq_empty;
  logic              cmdq_push;
  logic              load;
  backend_command_t  cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              rd_acc;
  logic              can_issue;
  logic [OUT_W-1:0]  out_q;
  logic [OUT_W-1:0]  out_next;
  logic              tagq_full;
  logic              tagq_empty;
  logic [TAG_W-1:0]  tagq_head;
  logic              rspq_full;
  logic              rspq_empty;
  logic              rsp_push;
  logic              rsp_pop;
  logic [TAG_W+DATA_W-1:0] rsp_head;
  logic              err_q;

  assign req_in = '{write: i_req_write, row: i_req_row, col: i_req_col,
                    tag: i_req_tag, wdata: i_req_wdata};
  assign o_req_ready = !cmdq_full;
  assign cmdq_push   = i_req_valid & !cmdq_full;

  sync_fifo #(.WIDTH($bits(issuer_req_t)), .DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk(clk), .rst_n(power_on_rst_n), .push(cmdq_push), .pop(load),
    .din(req_in), .full(cmdq_full), .empty(cmdq_empty), .head(cmdq_head)
  );

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(RD_MAX)) u_tagq (
    .clk(clk), .rst_n(power_on_rst_n), .push(rd_acc & !tagq_full),
    .pop(rsp_push), .din(tag_q), .full(tagq_full), .empty(tagq_empty),
    .head(tagq_head)
  );

  sync_fifo #(.WIDTH(TAG_W + DATA_W), .DEPTH(RD_MAX)) u_rspq (
    .clk(clk), .rst_n(power_on_rst_n), .push(rsp_push), .pop(rsp_pop),
    .din({tagq_head, i_backend_read_data}), .full(rspq_full),
    .empty(rspq_empty), .head(rsp_head)
  );

  assign o_frontend_command_valid = (state == S_SEND);
  assign o_frontend_command       = cmd_q;
  assign o_frontend_write_data    =
    (o_frontend_command_valid && cmd_q.op_type == OP_WRITE) ? wdata_q : '0;

  assign accept   = o_frontend_command_valid & i_backend_controller_ready;
  assign rd_acc   = accept & (cmd_q.op_type == OP_READ);
  assign rsp_pop  = o_rsp_valid & i_rsp_ready;
  assign out_next = out_q + OUT_W'(rd_acc) - OUT_W'(rsp_pop);
  assign can_issue = !cmdq_empty &
                     (cmdq_head.write | (out_next < OUT_W'(RD_MAX)));

  // Dropping data with no tag pending drains the backend even if rspq is full.
  assign o_backend_controller_ren =
    i_backend_read_data_valid & (tagq_empty | !rspq_full);
  assign rsp_push = i_backend_read_data_valid & !tagq_empty & !rspq_full;

  assign o_rsp_valid      = !rspq_empty;
  assign o_rsp_rdata      = o_rsp_valid ? rsp_head[DATA_W-1:0] : '0;
  assign o_rsp_tag        = o_rsp_valid ? rsp_head[DATA_W +: TAG_W] : '0;
  assign o_rd_outstanding = out_q;
  assign o_err            = err_q;

  // Issue FSM state register.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) state <= S_IDLE;
    else                  state <= nxt;
  end

  // Next state; load pulls the queue head into the command register.
  always_comb begin
    nxt  = state;
    load = 1'b0;
    unique case (state)
      S_IDLE, S_STALL: begin
        if (can_issue) begin
          load = 1'b1;
          nxt  = S_SEND;
        end else if (!cmdq_empty) begin
          nxt  = S_STALL;
        end else begin
          nxt  = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept) begin
          if (can_issue) begin
            load = 1'b1;
            nxt  = S_SEND;
          end else if (!cmdq_empty) begin
            nxt  = S_STALL;
          end else begin
            nxt  = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Command payload register, stable while waiting for backend ready.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      cmd_q   <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
    end else if (load) begin
      cmd_q.op_type  <= cmdq_head.write ? OP_WRITE : OP_READ;
      cmd_q.row_addr <= cmdq_head.row;
      cmd_q.col_addr <= cmdq_head.col;
      tag_q          <= cmdq_head.tag;
      wdata_q        <= cmdq_head.write ? cmdq_head.wdata : '0;
    end
  end

  // Outstanding read credit and sticky protocol error.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_next;
      if (i_backend_read_data_valid & tagq_empty) err_q <= 1'b1;
    end
  end

`ifdef ISSUER_PERF_CNT_EN
  logic stall_cyc;
  assign stall_cyc = (o_frontend_command_valid & !i_backend_controller_ready)
                   | (state == S_STALL);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      o_perf_rd_cnt    <= '0;
      o_perf_wr_cnt    <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (rd_acc && o_perf_rd_cnt != '1)
        o_perf_rd_cnt <= o_perf_rd_cnt + 1'b1;
      if (accept && !rd_acc && o_perf_wr_cnt != '1)
        o_perf_wr_cnt <= o_perf_wr_cnt + 1'b1;
      if (stall_cyc && o_perf_stall_cnt != '1)
        o_perf_stall_cnt <= o_perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Bench for frontend_cmd_issuer: directed stimulus, queue scoreboard,
// negedge monitor comparing issued commands and read responses.
module tb_frontend_cmd_issuer;
  import frontend_command_definition_pkg::*;

  localparam int CW = 1 + ROW_W + COL_W + DATA_W;
  localparam int RW = TAG_W + DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b1;
  logic                 req_valid = 0, req_ready, req_write = 0;
  logic [ROW_W-1:0]     req_row = '0;
  logic [COL_W-1:0]     req_col = '0;
  logic [TAG_W-1:0]     req_tag = '0;
  logic [DATA_W-1:0]    req_wdata = '0;
  logic                 rsp_valid, rsp_ready = 1'b1;
  logic [DATA_W-1:0]    rsp_rdata;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 cmd_valid, be_ready = 1'b1;
  backend_command_t     cmd;
  logic [DATA_W-1:0]    wdata;
  logic                 rdv = 1'b0;
  logic [DATA_W-1:0]    rdata = '0;
  logic                 ren;
  logic [OUT_W-1:0]     outst;
  logic                 err;
`ifdef ISSUER_PERF_CNT_EN
  logic [31:0] perf_rd, perf_wr, perf_stall;
`endif

  frontend_cmd_issuer dut (
    .clk(clk), .power_on_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_row(req_row), .i_req_col(req_col),
    .i_req_tag(req_tag), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_tag(rsp_tag),
    .o_frontend_command_valid(cmd_valid),
    .i_backend_controller_ready(be_ready),
    .o_frontend_command(cmd), .o_frontend_write_data(wdata),
    .i_backend_read_data_valid(rdv), .i_backend_read_data(rdata),
    .o_backend_controller_ren(ren), .o_rd_outstanding(outst),
    .o_err(err)
`ifdef ISSUER_PERF_CNT_EN
    , .o_perf_rd_cnt(perf_rd), .o_perf_wr_cnt(perf_wr),
    .o_perf_stall_cnt(perf_stall)
`endif
  );

  int errors = 0;
  int checks = 0;
  int ren_cnt = 0;
  logic [CW-1:0] exp_cmd [$];
  logic [RW-1:0] exp_rsp [$];

  function automatic void chk(string name, logic [255:0] got,
                              logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Monitor: compare every accepted command and popped response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren) ren_cnt++;
      if (cmd_valid && be_ready) begin
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got %0h expected none",
                   {cmd, wdata});
        end else begin
          chk("cmd", {cmd.op_type, cmd.row_addr, cmd.col_addr, wdata},
              exp_cmd.pop_front());
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got %0h expected none",
                   {rsp_tag, rsp_rdata});
        end else begin
          chk("rsp", {rsp_tag, rsp_rdata}, exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [ROW_W-1:0] row,
                          input logic [COL_W-1:0] col,
                          input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] wd);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_row = row;
    req_col = col; req_tag = tag; req_wdata = wd;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    else exp_cmd.push_back({w, row, col, w ? wd : '0});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic be_data(input logic [DATA_W-1:0] d);
    int n = 0;
    rdv = 1'b1; rdata = d;
    while (n < 50) begin
      @(negedge clk);
      if (ren) break;
      n++;
    end
    chk("ren_seen", ren, 1);
    @(posedge clk); #1;
    rdv = 1'b0; rdata = '0;
  endtask

  task automatic wait_outst(input int v);
    int n = 0;
    while (int'(outst) != v && n < 30) begin tick(); n++; end
  endtask

  function automatic logic [DATA_W-1:0] dpat(input int t);
    return {32{4'(t)}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outst", outst, 0);
    chk("rst_err", err, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 1);

    // Single write.
    send_req(1'b1, 14'd5, 4'd3, 4'd0, {16{8'hA5}});
    repeat (4) tick();
    chk("wr_issued", exp_cmd.size(), 0);
    chk("wr_no_rsp", rsp_valid, 0);
    chk("wr_outst", outst, 0);

    // Single read in last column slot.
    send_req(1'b0, 14'd9, 4'd15, 4'd7, '1);
    wait_outst(1);
    chk("rd_outst_1", outst, 1);
    exp_rsp.push_back({4'd7, 128'h1234});
    r0 = ren_cnt;
    be_data(128'h1234);
    repeat (3) tick();
    chk("ren_one_cycle", ren_cnt - r0, 1);
    chk("rd_outst_0", outst, 0);

    // Backend not ready: payload holds.
    be_ready = 1'b0;
    send_req(1'b1, 14'h3ABC, 4'hF, 4'd0, {4{32'hC0FFEE11}});
    begin
      int n = 0;
      while (!cmd_valid && n < 10) begin tick(); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", cmd_valid, 1);
      chk("stall_payload", {cmd, wdata},
          {1'b1, 14'h3ABC, 4'hF, {4{32'hC0FFEE11}}});
      tick();
    end
    be_ready = 1'b1;
    tick(); tick();
`ifdef ISSUER_PERF_CNT_EN
    chk("perf_stall", perf_stall, 5);
    chk("perf_wr", perf_wr, 2);
    chk("perf_rd", perf_rd, 1);
`endif

    // Five reads against four credits.
    rsp_ready = 1'b0;
    for (int t = 1; t <= 5; t++)
      send_req(1'b0, 14'(t), 4'(t), 4'(t), '0);
    repeat (6) tick();
    chk("credit_outst_4", outst, 4);
    chk("credit_stall", cmd_valid, 0);
    exp_rsp.push_back({4'd1, dpat(1)});
    be_data(dpat(1));
    tick();
    chk("credit_still_4", outst, 4);
    chk("credit_rsp_wait", rsp_valid, 1);
    chk("credit_still_stall", cmd_valid, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("fifth_issued", cmd_valid, 1);
    rsp_ready = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      exp_rsp.push_back({4'(t), dpat(t)});
      be_data(dpat(t));
    end
    repeat (4) tick();
    chk("credit_drained", outst, 0);
    chk("credit_rsp_empty", rsp_valid, 0);

    // Read data with nothing outstanding.
    chk("err_pre", err, 0);
    rdv = 1'b1; rdata = 128'hDEAD;
    @(negedge clk);
    chk("err_ren", ren, 1);
    @(posedge clk); #1;
    rdv = 1'b0; rdata = '0;
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    chk("err_no_rsp", rsp_valid, 0);
    chk("err_outst", outst, 0);

    // Reset with reads in flight and a full queue.
    send_req(1'b0, 14'd20, 4'd1, 4'd8, '0);
    send_req(1'b0, 14'd21, 4'd2, 4'd9, '0);
    repeat (4) tick();
    chk("flight_outst", outst, 2);
    be_ready = 1'b0;
    for (int t = 0; t < 5; t++)
      send_req(1'b1, 14'(30 + t), 4'(t), 4'd0, dpat(t + 6));
    chk("full_not_ready", req_ready, 0);
    chk("full_cmd_valid", cmd_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_outst", outst, 0);
    chk("mid_rst_err", err, 0);
    exp_cmd.delete();
    exp_rsp.delete();
    be_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("post_rst_ready", req_ready, 1);
    repeat (5) tick();
    chk("post_rst_idle", cmd_valid, 0);
    send_req(1'b0, 14'd40, 4'd4, 4'd3, '0);
    wait_outst(1);
    exp_rsp.push_back({4'd3, dpat(11)});
    be_data(dpat(11));
    repeat (3) tick();
    chk("post_rst_err", err, 0);
    chk("post_rst_outst", outst, 0);

    chk("cmd_sb_empty", exp_cmd.size(), 0);
    chk("rsp_sb_empty", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
